// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, drives a fixed-latency synchronous ROM,
// tracks in-flight reads and buffers returned words in a credit-limited queue.
module fetch_unit #(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 8,
    parameter int                INSTR_W  = DATA_W,
    parameter int                ROM_LAT  = 1,
    parameter int                QDEPTH   = ROM_LAT + 1,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               MAX10_CLK1_50,
    input  logic               reset,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [INSTR_W-1:0] rom_q,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               redir_valid,
    input  logic [1:0]         redir_type,
    input  logic [ADDR_W-1:0]  redir_base_pc,
    input  logic [15:0]        redir_imm,
    input  logic [25:0]        redir_jtarget,
    input  logic [31:0]        redir_reg,
    output logic [ADDR_W-1:0]  link_addr
);
    localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CNT_W = $clog2(QDEPTH + ROM_LAT + 2) + 1;

    typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;
    state_t state_q, state_d;

    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
    logic [ROM_LAT-1:0] tag_vld_q, tag_vld_d;
    logic [ADDR_W-1:0]  tag_pc_q [ROM_LAT];
    logic [ADDR_W-1:0]  tag_pc_d [ROM_LAT];
    logic [INSTR_W-1:0] q_instr_q [QDEPTH];
    logic [ADDR_W-1:0]  q_pc_q [QDEPTH];
    logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d, inflight;
    logic               redirect, issue, push, pop;
    logic [ADDR_W-1:0]  target;
    logic signed [31:0] br_off;
    logic [31:0]        br_full;
    logic               unused_bits;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(QDEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Redirect target: branch offsets are signed word counts relative to base+1.
    always_comb begin
        br_off  = {{16{redir_imm[15]}}, redir_imm};
        br_full = 32'(redir_base_pc) + 32'd1 + br_off;
        case (redir_type)
            2'b00:   target = br_full[ADDR_W-1:0];
            2'b01:   target = redir_jtarget[ADDR_W-1:0];
            default: target = redir_reg[ADDR_W-1:0];
        endcase
    end

    assign unused_bits = ^{br_full[31:ADDR_W], redir_jtarget[25:ADDR_W], redir_reg[31:ADDR_W]};

    always_comb begin
        inflight = '0;
        for (int i = 0; i < ROM_LAT; i++) begin
            inflight = inflight + CNT_W'(tag_vld_q[i]);
        end
    end

    // A word popped this cycle frees its slot in time for a fetch issued now.
    assign redirect    = redir_valid && (redir_type != 2'b11);
    assign instr_valid = (count_q != '0);
    assign pop         = instr_valid && instr_ready && !redirect;
    assign push        = tag_vld_q[ROM_LAT-1] && !redirect;
    assign issue       = !reset && !redirect &&
                         ((count_q + inflight) < (CNT_W'(QDEPTH) + CNT_W'(pop)));
    assign rom_addr    = reset ? RESET_PC : (issue ? pc_q : rom_addr_q);

    always_comb begin
        state_d    = redirect ? FLUSH : RUN;
        rom_addr_d = rom_addr;
        pc_d       = pc_q;
        if (redirect) begin
            pc_d = target;
        end else if (issue) begin
            pc_d = pc_q + 1'b1;
        end

        tag_vld_d[0] = issue;
        tag_pc_d[0]  = pc_q;
        for (int i = 1; i < ROM_LAT; i++) begin
            tag_vld_d[i] = tag_vld_q[i-1] && !redirect;
            tag_pc_d[i]  = tag_pc_q[i-1];
        end

        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (redirect) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) tail_d = ptr_inc(tail_q);
            if (pop)  head_d = ptr_inc(head_q);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge MAX10_CLK1_50) begin
        if (reset) begin
            state_q    <= RUN;
            pc_q       <= RESET_PC;
            rom_addr_q <= RESET_PC;
            tag_vld_q  <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            rom_addr_q <= rom_addr_d;
            tag_vld_q  <= tag_vld_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
        end
        tag_pc_q <= tag_pc_d;
        if (push) begin
            q_instr_q[tail_q] <= rom_q;
            q_pc_q[tail_q]    <= tag_pc_q[ROM_LAT-1];
        end
    end

    assign instr     = instr_valid ? q_instr_q[head_q] : '0;
    assign instr_pc  = instr_valid ? q_pc_q[head_q] : '0;
    assign link_addr = instr_pc + ADDR_W'(2);

    a_no_overflow: assert property (@(posedge MAX10_CLK1_50) disable iff (reset)
        !(push && !pop && (count_q == CNT_W'(QDEPTH))));
    a_flush_one_cycle: assert property (@(posedge MAX10_CLK1_50) disable iff (reset)
        (state_q == FLUSH && !redirect) |=> (state_q == RUN));
endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: one instance with ROM_LAT=1/QDEPTH=2, one with ROM_LAT=3/QDEPTH=4.
module tb_fetch_unit;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  rst, rdy, rv, ivld;
    logic [7:0]  rom_addr [2];
    logic [31:0] rom_q [2];
    logic [31:0] instr [2];
    logic [7:0]  ipc [2];
    logic [7:0]  link [2];
    logic [1:0]  rtype;
    logic [7:0]  rbase;
    logic [15:0] rimm;
    logic [25:0] rjt;
    logic [31:0] rreg;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int n_deliv [2];
    logic [7:0] exq0[$];
    logic [7:0] exq1[$];
    logic [7:0] mon_e;
    logic [31:0] romp [2][3];

    fetch_unit #(.ADDR_W(8), .INSTR_W(32), .ROM_LAT(1), .QDEPTH(2), .RESET_PC(8'h00)) u_dut1 (
        .MAX10_CLK1_50(clk), .reset(rst[0]), .rom_addr(rom_addr[0]), .rom_q(rom_q[0]),
        .instr(instr[0]), .instr_pc(ipc[0]), .instr_valid(ivld[0]), .instr_ready(rdy[0]),
        .redir_valid(rv[0]), .redir_type(rtype), .redir_base_pc(rbase), .redir_imm(rimm),
        .redir_jtarget(rjt), .redir_reg(rreg), .link_addr(link[0]));

    fetch_unit #(.ADDR_W(8), .INSTR_W(32), .ROM_LAT(3), .QDEPTH(4), .RESET_PC(8'h00)) u_dut3 (
        .MAX10_CLK1_50(clk), .reset(rst[1]), .rom_addr(rom_addr[1]), .rom_q(rom_q[1]),
        .instr(instr[1]), .instr_pc(ipc[1]), .instr_valid(ivld[1]), .instr_ready(rdy[1]),
        .redir_valid(rv[1]), .redir_type(rtype), .redir_base_pc(rbase), .redir_imm(rimm),
        .redir_jtarget(rjt), .redir_reg(rreg), .link_addr(link[1]));

    function automatic logic [31:0] rom_word(input logic [7:0] a);
        return 32'h1000_0000 + {24'h0, a};
    endfunction

    // ROM model: ROM[i] = 0x1000_0000 + i, latency 1 or 3 cycles.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int k = 0; k < 2; k++) begin
            romp[k][0] <= rom_word(rom_addr[k]);
            romp[k][1] <= romp[k][0];
            romp[k][2] <= romp[k][1];
        end
    end
    assign rom_q[0] = romp[0][0];
    assign rom_q[1] = romp[1][2];

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s dut%0d actual=%0h required=%0h", nm, k, act, req);
        end
    endtask

    function automatic void exp_clear(input int k);
        if (k == 0) exq0.delete(); else exq1.delete();
    endfunction

    function automatic void exp_seq(input int k, input logic [7:0] start, input int n);
        for (int i = 0; i < n; i++) begin
            if (k == 0) exq0.push_back(start + 8'(i));
            else        exq1.push_back(start + 8'(i));
        end
    endfunction

    function automatic int exp_size(input int k);
        return (k == 0) ? exq0.size() : exq1.size();
    endfunction

    function automatic logic [7:0] exp_pop(input int k);
        return (k == 0) ? exq0.pop_front() : exq1.pop_front();
    endfunction

    // Monitor: every accepted word must be the next expected PC with its ROM word and link.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst[k] && !(rv[k] && rtype != 2'b11) && ivld[k] && rdy[k]) begin
                n_deliv[k]++;
                if (exp_size(k) == 0) begin
                    chk("mon_unexpected_word", k, {24'h0, ipc[k]}, 32'hFFFF_FFFF);
                end else begin
                    mon_e = exp_pop(k);
                    chk("mon_pc", k, {24'h0, ipc[k]}, {24'h0, mon_e});
                    chk("mon_instr", k, instr[k], rom_word(mon_e));
                    chk("mon_link", k, {24'h0, link[k]}, {24'h0, 8'(mon_e + 8'd2)});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic first_valid(input int k, input int c_ref, input int exp_lat, input string nm);
        int seen;
        seen = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ivld[k]) begin
                seen = cyc - c_ref;
                break;
            end
        end
        chk(nm, k, 32'(seen), 32'(exp_lat));
    endtask

    task automatic wait_n(input int k, input int n, input string nm);
        int tgt;
        tgt = n_deliv[k] + n;
        for (int i = 0; i < 200 && n_deliv[k] < tgt; i++) tick();
        chk(nm, k, 32'(n_deliv[k] >= tgt), 32'd1);
    endtask

    task automatic suite(input int k, input int lat, input int depth);
        int c_ref;
        logic [7:0] held;
        rst[k] = 1'b1; rdy[k] = 1'b0; rv[k] = 1'b0;
        exp_clear(k);
        tick(); tick();
        chk("rst_valid", k, {31'h0, ivld[k]}, 32'd0);
        chk("rst_instr", k, instr[k], 32'd0);
        chk("rst_pc", k, {24'h0, ipc[k]}, 32'd0);
        chk("rst_rom_addr", k, {24'h0, rom_addr[k]}, 32'd0);

        rst[k] = 1'b0; rdy[k] = 1'b1;
        exp_seq(k, 8'h00, 64);
        c_ref = cyc;
        first_valid(k, c_ref, lat + 1, "latency_after_reset");
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("throughput", k, {31'h0, ivld[k]}, 32'd1);
        end

        // Stall: the queue fills and fetch stops one word past the head-of-queue window.
        tick(); rdy[k] = 1'b0;
        repeat (5) tick();
        @(negedge clk);
        held = rom_addr[k];
        chk("stall_valid", k, {31'h0, ivld[k]}, 32'd1);
        chk("stall_full_addr", k, {24'h0, rom_addr[k]}, {24'h0, 8'(ipc[k] + 8'(depth - 1))});
        @(negedge clk);
        chk("stall_addr_hold", k, {24'h0, rom_addr[k]}, {24'h0, held});
        tick(); rdy[k] = 1'b1;
        wait_n(k, 10, "stall_resume");

        // Branch backwards: 0x10 + 1 - 4 = 0x0D.
        tick();
        rv[k] = 1'b1; rtype = 2'b00; rbase = 8'h10; rimm = 16'hFFFC;
        exp_clear(k); exp_seq(k, 8'h0D, 32);
        c_ref = cyc;
        tick(); rv[k] = 1'b0;
        first_valid(k, c_ref, lat + 2, "latency_branch");
        wait_n(k, 6, "branch_run");

        // Jump while stalled, immediately overridden by jr.
        tick(); rdy[k] = 1'b0;
        repeat (5) tick();
        rv[k] = 1'b1; rtype = 2'b01; rjt = 26'h3FF_FF20;
        exp_clear(k);
        tick();
        chk("flush_without_ready", k, {31'h0, ivld[k]}, 32'd0);
        rtype = 2'b10; rreg = 32'hDEAD_BE42;
        exp_clear(k); exp_seq(k, 8'h42, 32);
        c_ref = cyc;
        tick(); rv[k] = 1'b0; rdy[k] = 1'b1;
        first_valid(k, c_ref, lat + 2, "latency_jr");
        wait_n(k, 6, "jr_run");

        // PC wrap 0xFF -> 0x00, then a reserved-type request that must not disturb the stream.
        tick();
        rv[k] = 1'b1; rtype = 2'b01; rjt = 26'h000_00FD;
        exp_clear(k); exp_seq(k, 8'hFD, 40);
        tick(); rv[k] = 1'b0;
        wait_n(k, 6, "wrap_run");
        rv[k] = 1'b1; rtype = 2'b11;
        tick(); rv[k] = 1'b0;
        wait_n(k, 6, "reserved_run");

        // Reset while words are queued and a read is in flight.
        tick(); rdy[k] = 1'b0;
        tick();
        rst[k] = 1'b1;
        exp_clear(k);
        tick();
        rst[k] = 1'b0; rdy[k] = 1'b1;
        exp_seq(k, 8'h00, 32);
        c_ref = cyc;
        chk("reset_mid_valid", k, {31'h0, ivld[k]}, 32'd0);
        first_valid(k, c_ref, lat + 1, "latency_reset_mid");
        wait_n(k, 6, "reset_mid_run");
        tick(); rdy[k] = 1'b0;
        tick();
    endtask

    initial begin
        rst = 2'b11; rdy = 2'b00; rv = 2'b00;
        rtype = 2'b00; rbase = 8'h00; rimm = 16'h0; rjt = 26'h0; rreg = 32'h0;
        n_deliv[0] = 0; n_deliv[1] = 0;
        tick(); tick();
        suite(0, 1, 2);
        suite(1, 3, 4);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end
endmodule
